// File: rtl/fma16_op_queue.sv
// Operand FIFO, combinational half-precision fused multiply-add, and registered result stage.
// Define FMA16_STICKY_FLAGS_EN to add the sticky_clr/sticky_flags accumulator.

module fma16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic [5:0]  ctrl,
  output logic [15:0] result,
  output logic [3:0]  flags
);
  logic [1:0]  rm;
  logic        mul, add, negp, negz;
  logic [15:0] ye, ze;
  logic        ps, zs, sgn;
  logic [21:0] pm;
  logic [81:0] prod, zv, mag, lowmask;
  logic [6:0]  lead, lsb;
  logic [11:0] keep, rnd;
  logic [15:0] enc;
  logic        tiny, rbit, sticky, inexact, inc, ovf;
  logic        nan_in, invalid, pinf, zinf;

  function automatic logic is_inf(input logic [15:0] v);
    return v[14:0] == 15'h7c00;
  endfunction
  function automatic logic is_nan(input logic [15:0] v);
    return (v[14:10] == 5'h1f) && (v[9:0] != 10'd0);
  endfunction
  function automatic logic is_snan(input logic [15:0] v);
    return is_nan(v) && !v[9];
  endfunction
  function automatic logic is_zero(input logic [15:0] v);
    return v[14:0] == 15'd0;
  endfunction
  function automatic logic [10:0] mant(input logic [15:0] v);
    return {(v[14:10] != 5'd0), v[9:0]};
  endfunction
  function automatic logic [4:0] expo(input logic [15:0] v);
    return (v[14:10] == 5'd0) ? 5'd1 : v[14:10];
  endfunction

  // Disabled multiply means y = 1.0; disabled add means z = 0 carrying the product's sign.
  assign {rm, mul, add, negp, negz} = ctrl;
  assign ye = mul ? y : 16'h3c00;
  assign ze = add ? z : 16'h0000;
  assign ps = x[15] ^ ye[15] ^ negp;
  assign zs = add ? (z[15] ^ negz) : ps;

  // Exact sum held as an integer scaled by 2^48, so the smallest product (2^-48) is bit 0.
  always_comb begin
    pm   = 22'(mant(x)) * 22'(mant(ye));
    prod = {60'd0, pm} << (6'(expo(x)) + 6'(expo(ye)) - 6'd2);
    zv   = {71'd0, mant(ze)} << (6'(expo(ze)) + 6'd23);
    if (ps == zs) begin
      mag = prod + zv;
      sgn = ps;
    end else if (prod >= zv) begin
      mag = prod - zv;
      sgn = ps;
    end else begin
      mag = zv - prod;
      sgn = zs;
    end
    if (mag == '0) sgn = (ps == zs) ? ps : (rm == 2'b10);
    lead = '0;
    for (int i = 0; i < 82; i++) if (mag[i]) lead = 7'(i);
    tiny    = lead < 7'd34;
    lsb     = tiny ? 7'd24 : lead - 7'd10;
    keep    = 12'(mag >> lsb);
    rbit    = mag[lsb - 7'd1];
    lowmask = (82'd1 << (lsb - 7'd1)) - 82'd1;
    sticky  = |(mag & lowmask);
    case (rm)
      2'b00:   inc = 1'b0;
      2'b01:   inc = rbit & (sticky | keep[0]);
      2'b10:   inc = (rbit | sticky) & sgn;
      default: inc = (rbit | sticky) & ~sgn;
    endcase
    rnd = keep + 12'(inc);
    // Biased exponent minus one, shifted up, plus the rounded significand lets a carry bump the exponent.
    enc = tiny ? 16'(rnd) : (((16'(lead) - 16'd34) << 10) + 16'(rnd));
    ovf     = enc >= 16'h7c00;
    inexact = rbit | sticky | ovf;
    result  = {sgn, enc[14:0]};
    flags   = {1'b0, ovf, tiny & inexact, inexact};
    if (ovf)
      result = {sgn, ((rm == 2'b00) || (rm == 2'b10 && !sgn) || (rm == 2'b11 && sgn)) ? 15'h7bff : 15'h7c00};

    nan_in  = is_nan(x) | is_nan(ye) | is_nan(ze);
    pinf    = is_inf(x) | is_inf(ye);
    zinf    = is_inf(ze);
    invalid = is_snan(x) | is_snan(ye) | is_snan(ze)
            | (is_inf(x) & is_zero(ye)) | (is_zero(x) & is_inf(ye))
            | (pinf & zinf & (ps != zs));
    if (nan_in | invalid) begin
      result = 16'h7e00;
      flags  = {invalid, 3'b000};
    end else if (pinf | zinf) begin
      result = {pinf ? ps : zs, 15'h7c00};
      flags  = 4'b0000;
    end
  end
endmodule

module fma16_op_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  input  logic [15:0] in_z,
  input  logic [5:0]  in_ctrl,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [3:0]  out_flags
`ifdef FMA16_STICKY_FLAGS_EN
  ,
  input  logic        sticky_clr,
  output logic [3:0]  sticky_flags
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [53:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, issue;
  logic [53:0]   head;
  logic [15:0]   fma_result;
  logic [3:0]    fma_flags;

  assign full     = count == CW'(DEPTH);
  assign empty    = count == '0;
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign issue    = !empty && (!out_valid || out_ready);
  assign head     = mem[rd_ptr];

  fma16 u_fma16 (
    .x      (head[53:38]),
    .y      (head[37:22]),
    .z      (head[21:6]),
    .ctrl   (head[5:0]),
    .result (fma_result),
    .flags  (fma_flags)
  );

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_x, in_y, in_z, in_ctrl};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_result <= 16'h0000;
      out_flags  <= 4'b0000;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      if (push && !issue)      count <= count + 1'b1;
      else if (!push && issue) count <= count - 1'b1;
      if (issue) begin
        out_valid  <= 1'b1;
        out_result <= fma_result;
        out_flags  <= fma_flags;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef FMA16_STICKY_FLAGS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        sticky_flags <= 4'b0000;
    else if (sticky_clr)              sticky_flags <= 4'b0000;
    else if (out_valid && out_ready)  sticky_flags <= sticky_flags | out_flags;
  end
`endif
endmodule
